// File: rtl/fpga_link_shift_register_pkg.sv
// rtl/fpga_link_shift_register_pkg.sv - shared state encodings and link constants for the serial link shift engine
// Optional parity framing is selected with FPGA_LINK_PARITY_EN.
package fpga_link_shift_register_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } link_state_e;

    localparam logic LINK_IDLE_LEVEL = 1'b1;

`ifdef FPGA_LINK_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/fpga_bit_counter.sv
// rtl/fpga_bit_counter.sv - clearable bit counter with terminal-count compare
module fpga_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/fpga_link_shift_register.sv
// rtl/fpga_link_shift_register.sv - full-duplex shift engine for the FPGA-to-FPGA serial link
// Define FPGA_LINK_PARITY_EN to append an even-parity bit to every frame.
module fpga_link_shift_register
    import fpga_link_shift_register_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in_p,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    input  logic             data_in_s,
    output logic             tx_serial,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             frame_done,
    output logic             parity_err
);

    localparam int FRAME_BITS = WIDTH + PARITY_BITS;
    localparam int CNT_W      = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    link_state_e           state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0]      data_out_q, data_out_d;

    logic [FRAME_BITS-1:0] load_frame;
    logic [FRAME_BITS-1:0] shifted;
    logic [WIDTH-1:0]      rx_word;
    logic                  out_bit;
    logic                  cnt_clear;
    logic                  cnt_en;
    logic                  cnt_tc;
    logic [CNT_W-1:0]      cnt_value;

`ifdef FPGA_LINK_PARITY_EN
    logic perr_q, perr_d;
    logic rx_par;
`endif

    fpga_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk_i    (clock),
        .resetn_i (reset),
        .clear_i  (cnt_clear),
        .en_i     (cnt_en),
        .term_i   (LAST_BIT),
        .count_o  (cnt_value),
        .tc_o     (cnt_tc)
    );

    // The frame register is oriented so the output end is always the next bit
    // to leave and the received bits pile up from the opposite end.
    always_comb begin
`ifdef FPGA_LINK_PARITY_EN
        if (MSB_FIRST != 0) begin
            load_frame = {data_in_p, ^data_in_p};
            shifted    = {shreg_q[FRAME_BITS-2:0], data_in_s};
            rx_word    = shifted[FRAME_BITS-1:1];
            rx_par     = shifted[0];
        end else begin
            load_frame = {^data_in_p, data_in_p};
            shifted    = {data_in_s, shreg_q[FRAME_BITS-1:1]};
            rx_word    = shifted[WIDTH-1:0];
            rx_par     = shifted[FRAME_BITS-1];
        end
`else
        load_frame = data_in_p;
        if (MSB_FIRST != 0) begin
            shifted = {shreg_q[FRAME_BITS-2:0], data_in_s};
        end else begin
            shifted = {data_in_s, shreg_q[FRAME_BITS-1:1]};
        end
        rx_word = shifted;
`endif
        out_bit = (MSB_FIRST != 0) ? shreg_q[FRAME_BITS-1] : shreg_q[0];
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
`ifdef FPGA_LINK_PARITY_EN
        perr_d     = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = load_frame;
                    cnt_clear = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    shreg_d = shifted;
                    cnt_en  = 1'b1;
                    // Capture on the final strobe so data_out is already valid in DONE.
                    if (cnt_tc) begin
                        state_d    = ST_DONE;
                        data_out_d = rx_word;
`ifdef FPGA_LINK_PARITY_EN
                        perr_d     = (rx_par != ^rx_word);
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            data_out_q <= '0;
`ifdef FPGA_LINK_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
`ifdef FPGA_LINK_PARITY_EN
            perr_q     <= perr_d;
`endif
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign tx_serial  = (state_q == ST_SHIFT) ? out_bit : LINK_IDLE_LEVEL;
    assign data_out   = data_out_q;

`ifdef FPGA_LINK_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_link_shift_register.sv
// tb/tb_fpga_link_shift_register.sv - self-checking bench for fpga_link_shift_register (MSB- and LSB-first instances)
module tb_fpga_link_shift_register;

    localparam int W = 8;
`ifdef FPGA_LINK_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB = W + PB;
    localparam int P  = FB + 2;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] data_in_p;
    logic         load_valid;
    logic         shift_en;
    logic         data_in_s;

    logic         load_ready_m, tx_m, busy_m, done_m, perr_m;
    logic [W-1:0] dout_m;
    logic         load_ready_l, tx_l, busy_l, done_l, perr_l;
    logic [W-1:0] dout_l;

    int checks   = 0;
    int failures = 0;
    logic last_perr = 1'b0;

    always #5 clock = ~clock;

    fpga_link_shift_register #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clock      (clock),
        .reset      (reset),
        .data_in_p  (data_in_p),
        .load_valid (load_valid),
        .load_ready (load_ready_m),
        .shift_en   (shift_en),
        .data_in_s  (data_in_s),
        .tx_serial  (tx_m),
        .data_out   (dout_m),
        .busy       (busy_m),
        .frame_done (done_m),
        .parity_err (perr_m)
    );

    fpga_link_shift_register #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clock      (clock),
        .reset      (reset),
        .data_in_p  (data_in_p),
        .load_valid (load_valid),
        .load_ready (load_ready_l),
        .shift_en   (shift_en),
        .data_in_s  (data_in_s),
        .tx_serial  (tx_l),
        .data_out   (dout_l),
        .busy       (busy_l),
        .frame_done (done_l),
        .parity_err (perr_l)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bit k of a frame is the k-th bit on the wire.
    function automatic logic exp_tx(input logic [W-1:0] word, input int k, input bit msb);
        if (k >= W) return ^word;
        return msb ? word[W-1-k] : word[k];
    endfunction

    function automatic logic [W-1:0] model_word(input logic [FB-1:0] rx, input bit msb);
        logic [W-1:0] w = '0;
        for (int k = 0; k < W; k++) begin
            if (msb) w[W-1-k] = rx[k];
            else     w[k]     = rx[k];
        end
        return w;
    endfunction

    function automatic logic model_perr(input logic [FB-1:0] rx);
`ifdef FPGA_LINK_PARITY_EN
        return rx[W] != ^rx[W-1:0];
`else
        return rx[0] & 1'b0;
`endif
    endfunction

    task automatic check_idle(input string tag, input logic [W-1:0] em, input logic [W-1:0] el);
        chk1({tag, "_ready_m"}, load_ready_m, 1'b1);
        chk1({tag, "_ready_l"}, load_ready_l, 1'b1);
        chk1({tag, "_busy_m"}, busy_m, 1'b0);
        chk1({tag, "_tx_m"}, tx_m, 1'b1);
        chk1({tag, "_tx_l"}, tx_l, 1'b1);
        chk1({tag, "_done_m"}, done_m, 1'b0);
        chk8({tag, "_dout_m"}, dout_m, em);
        chk8({tag, "_dout_l"}, dout_l, el);
        chk1({tag, "_perr_m"}, perr_m, last_perr);
    endtask

    // One frame: load at a negedge, strobe every gap-th cycle, check DONE and return to IDLE.
    task automatic do_frame(input logic [W-1:0] word, input logic [FB-1:0] rx, input int gap,
                            input logic [W-1:0] em, input logic [W-1:0] el);
        logic ep;
        ep = model_perr(rx);
        @(negedge clock);
        data_in_p  = word;
        load_valid = 1'b1;
        shift_en   = 1'b0;
        chk1("load_ready_m", load_ready_m, 1'b1);
        chk1("load_ready_l", load_ready_l, 1'b1);
        @(negedge clock);
        load_valid = 1'b0;
        data_in_p  = W'($urandom);
        for (int k = 0; k < FB; k++) begin
            for (int g = 1; g < gap; g++) begin
                shift_en  = 1'b0;
                data_in_s = 1'($urandom);
                chk1("tx_hold_m", tx_m, exp_tx(word, k, 1'b1));
                chk1("done_gap_m", done_m, 1'b0);
                @(negedge clock);
            end
            shift_en  = 1'b1;
            data_in_s = rx[k];
            chk1("tx_m", tx_m, exp_tx(word, k, 1'b1));
            chk1("tx_l", tx_l, exp_tx(word, k, 1'b0));
            chk1("busy_m", busy_m, 1'b1);
            chk1("ready_shift_l", load_ready_l, 1'b0);
            chk1("done_early_m", done_m, 1'b0);
            @(negedge clock);
        end
        shift_en = 1'b0;
        chk1("done_m", done_m, 1'b1);
        chk1("done_l", done_l, 1'b1);
        chk8("data_out_m", dout_m, em);
        chk8("data_out_l", dout_l, el);
        chk1("parity_err_m", perr_m, ep);
        chk1("parity_err_l", perr_l, ep);
        chk1("tx_done_m", tx_m, 1'b1);
        chk1("ready_done_m", load_ready_m, 1'b0);
        last_perr = ep;
        @(negedge clock);
        check_idle("post", em, el);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] rx_word;
        logic         rx_par;
        int           gap;
        logic [W-1:0] exp_m;
        logic [W-1:0] exp_l;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [FB-1:0] rx;
        logic [W-1:0]  cur_word;
        logic [W-1:0]  keep_m, keep_l;

        vecs[0] = '{8'hA5, 8'hA5, 1'b0, 1, 8'hA5, 8'hA5};
        vecs[1] = '{8'h01, 8'h3C, 1'b0, 3, 8'h3C, 8'h3C};
        vecs[2] = '{8'h07, 8'h07, 1'b1, 1, 8'h07, 8'hE0};
        vecs[3] = '{8'h07, 8'h07, 1'b0, 2, 8'h07, 8'hE0};
        vecs[4] = '{8'h12, 8'h0F, 1'b0, 1, 8'h0F, 8'hF0};
        vecs[5] = '{8'hC3, 8'h80, 1'b1, 2, 8'h80, 8'h01};

        reset      = 1'b0;
        data_in_p  = '0;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        data_in_s  = 1'b0;
        repeat (2) @(negedge clock);
        check_idle("reset", 8'h00, 8'h00);
        chk1("reset_perr_l", perr_l, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            rx = '0;
            for (int k = 0; k < W; k++) rx[k] = vecs[i].rx_word[W-1-k];
`ifdef FPGA_LINK_PARITY_EN
            rx[W] = vecs[i].rx_par;
`endif
            do_frame(vecs[i].word, rx, vecs[i].gap, vecs[i].exp_m, vecs[i].exp_l);
        end

        // Strobes and serial activity while idle must be ignored.
        keep_m = dout_m;
        keep_l = dout_l;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            shift_en  = 1'b1;
            data_in_s = 1'(c);
            check_idle("idle_strobe", keep_m, keep_l);
        end
        @(negedge clock);
        shift_en = 1'b0;
        do_frame(8'h81, FB'(9'h0FF), 1, model_word(FB'(9'h0FF), 1'b1), model_word(FB'(9'h0FF), 1'b0));

        // Reset in the middle of a frame aborts it.
        @(negedge clock);
        data_in_p  = 8'hFF;
        load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        shift_en   = 1'b1;
        repeat (4) @(negedge clock);
        shift_en = 1'b0;
        reset    = 1'b0;
        @(negedge clock);
        reset     = 1'b1;
        last_perr = 1'b0;
        check_idle("abort", 8'h00, 8'h00);
        rx = '0;
        for (int k = 0; k < W; k++) rx[k] = exp_tx(8'h5A, k, 1'b1);
`ifdef FPGA_LINK_PARITY_EN
        rx[W] = ^8'h5A;
`endif
        do_frame(8'h5A, rx, 1, 8'h5A, 8'h5A);

        // Randomised frames with random strobe spacing.
        for (int i = 0; i < 10; i++) begin
            rx = FB'($urandom);
            do_frame(W'($urandom), rx, int'($urandom_range(1, 3)), model_word(rx, 1'b1), model_word(rx, 1'b0));
        end

        // Continuous load_valid and shift_en: frames repeat every FB+2 cycles.
        cur_word = '0;
        rx       = '0;
        for (int c = 0; c < 3 * P; c++) begin
            int ph;
            ph = c % P;
            @(negedge clock);
            data_in_p  = W'($urandom);
            load_valid = 1'b1;
            shift_en   = 1'b1;
            data_in_s  = 1'($urandom);
            if (ph == 0) begin
                chk1("b2b_ready_m", load_ready_m, 1'b1);
                chk1("b2b_perr_hold", perr_m, last_perr);
                cur_word = data_in_p;
            end else if (ph <= FB) begin
                chk1("b2b_ready_busy", load_ready_m, 1'b0);
                chk1("b2b_tx_m", tx_m, exp_tx(cur_word, ph - 1, 1'b1));
                chk1("b2b_tx_l", tx_l, exp_tx(cur_word, ph - 1, 1'b0));
                rx[ph-1] = data_in_s;
            end else begin
                chk1("b2b_done_m", done_m, 1'b1);
                chk8("b2b_dout_m", dout_m, model_word(rx, 1'b1));
                chk8("b2b_dout_l", dout_l, model_word(rx, 1'b0));
                chk1("b2b_perr_m", perr_m, model_perr(rx));
                last_perr = model_perr(rx);
            end
        end
        @(negedge clock);
        load_valid = 1'b0;
        shift_en   = 1'b0;
        chk1("b2b_end_ready", load_ready_m, 1'b1);
        repeat (2) @(negedge clock);
        chk1("b2b_end_idle", busy_m, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
